// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU operand-issue / writeback controller.
// Holds the FSM encoding, ALU opcode map and datapath widths.
package alu_issue_ctrl_pkg;

    localparam int W    = 16;
    localparam int NREG = 4;
    localparam int RW   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OPC_NEG   = 3'b000;
    localparam logic [2:0] OPC_INC   = 3'b001;
    localparam logic [2:0] OPC_ADD   = 3'b010;
    localparam logic [2:0] OPC_ADDSH = 3'b011;
    localparam logic [2:0] OPC_AND   = 3'b100;
    localparam logic [2:0] OPC_OR    = 3'b101;
    localparam logic [2:0] OPC_CAT   = 3'b110;
    localparam logic [2:0] OPC_LOAD  = 3'b111;

    function automatic logic is_zero(input logic [W-1:0] v);
        return (v == '0);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x16 register file: two asynchronous operand read ports, one debug read
// port, one synchronous write port, asynchronous active-low clear.
module alu_regfile
    import alu_issue_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [RW-1:0] ra_sel,
    output logic [W-1:0]  ra_data,
    input  logic [RW-1:0] rb_sel,
    output logic [W-1:0]  rb_data,
    input  logic [RW-1:0] dbg_sel,
    output logic [W-1:0]  dbg_data
);

    logic [W-1:0] mem_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign ra_data  = mem_q[ra_sel];
    assign rb_data  = mem_q[rb_sel];
    assign dbg_data = mem_q[dbg_sel];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to an external 16-bit ALU, writes the
// result back to the register file and holds it on a backpressured response port.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_opc,
    input  logic [RW-1:0] instr_rd,
    input  logic [RW-1:0] instr_ra,
    input  logic [RW-1:0] instr_rb,
    input  logic          instr_cin,
    input  logic [W-1:0]  instr_imm,
    output logic [2:0]    alu_opc,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic          alu_c,
    input  logic [W-1:0]  alu_w,
    input  logic          alu_zer,
    input  logic          alu_neg,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_data,
    output logic [RW-1:0] res_rd,
    output logic          zf,
    output logic          nf,
    input  logic [RW-1:0] dbg_sel,
    output logic [W-1:0]  dbg_data
);

    state_t state_q, state_d;

    logic [2:0]    opc_q;
    logic [RW-1:0] rd_q;
    logic          cin_q;
    logic [W-1:0]  imm_q;
    logic [W-1:0]  opa_q;
    logic [W-1:0]  opb_q;
    logic [W-1:0]  res_data_q;
    logic [RW-1:0] res_rd_q;
    logic          zf_q;
    logic          nf_q;

    logic [W-1:0]  ra_data;
    logic [W-1:0]  rb_data;
    logic          accept;
    logic          wb_en;
    logic          is_load;
    logic [W-1:0]  wb_data;
    logic          wb_zer;
    logic          wb_neg;

    alu_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wb_en),
        .waddr    (rd_q),
        .wdata    (wb_data),
        .ra_sel   (instr_ra),
        .ra_data  (ra_data),
        .rb_sel   (instr_rb),
        .rb_data  (rb_data),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign accept  = instr_valid && instr_ready;
    assign wb_en   = (state_q == ST_EXEC);
    assign is_load = (opc_q == OPC_LOAD);
    // LOAD bypasses the ALU entirely, including its flag outputs.
    assign wb_data = is_load ? imm_q : alu_w;
    assign wb_zer  = is_load ? is_zero(imm_q) : alu_zer;
    assign wb_neg  = is_load ? imm_q[W-1] : alu_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q      <= '0;
            rd_q       <= '0;
            cin_q      <= 1'b0;
            imm_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
            zf_q       <= 1'b0;
            nf_q       <= 1'b0;
        end else begin
            if (accept) begin
                opc_q <= instr_opc;
                rd_q  <= instr_rd;
                cin_q <= instr_cin;
                imm_q <= instr_imm;
                opa_q <= ra_data;
                opb_q <= rb_data;
            end
            if (wb_en) begin
                res_data_q <= wb_data;
                res_rd_q   <= rd_q;
                zf_q       <= wb_zer;
                nf_q       <= wb_neg;
            end
        end
    end

    // Operand registers only change on accept, so the ALU inputs hold outside EXEC.
    assign alu_opc  = opc_q;
    assign alu_a    = opa_q;
    assign alu_b    = opb_q;
    assign alu_c    = cin_q;
    assign res_data = res_data_q;
    assign res_rd   = res_rd_q;
    assign zf       = zf_q;
    assign nf       = nf_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 16-bit ALU attached.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_opc;
    logic [1:0]  instr_rd, instr_ra, instr_rb;
    logic        instr_cin;
    logic [15:0] instr_imm;
    logic [2:0]  alu_opc;
    logic [15:0] alu_a, alu_b;
    logic        alu_c;
    logic [15:0] alu_w;
    logic        alu_zer, alu_neg;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic [1:0]  res_rd;
    logic        zf, nf;
    logic [1:0]  dbg_sel;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opc(instr_opc), .instr_rd(instr_rd), .instr_ra(instr_ra),
        .instr_rb(instr_rb), .instr_cin(instr_cin), .instr_imm(instr_imm),
        .alu_opc(alu_opc), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_rd(res_rd), .zf(zf), .nf(nf),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    // Behavioural ALU
    always_comb begin
        alu_w = 16'h0000;
        case (alu_opc)
            3'b000: alu_w = 16'h0000 - alu_a;
            3'b001: alu_w = alu_a + 16'h0001;
            3'b010: alu_w = alu_a + alu_b + {15'h0000, alu_c};
            3'b011: alu_w = alu_a + 16'($signed(alu_b) >>> 1);
            3'b100: alu_w = alu_a & alu_b;
            3'b101: alu_w = alu_a | alu_b;
            3'b110: alu_w = {alu_a[7:0], alu_b[7:0]};
            default: alu_w = 16'h0000;
        endcase
        alu_zer = (alu_w == 16'h0000);
        alu_neg = alu_w[15];
    end

    task automatic read_reg(input logic [1:0] sel, output logic [15:0] val);
        dbg_sel = sel;
        #1;
        val = dbg_data;
    endtask

    // Issue one instruction, wait for the response, capture it, then handshake.
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] rd,
                             input logic [1:0] ra, input logic [1:0] rb,
                             input logic cin, input logic [15:0] imm,
                             output logic [15:0] data, output logic [1:0] rdo,
                             output logic z, output logic n, output int lat);
        int waits;
        data = 16'h0; rdo = 2'd0; z = 1'b0; n = 1'b0; lat = 0;
        waits = 0;
        @(negedge clk);
        while (!instr_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!instr_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: instr_ready=%0b required 1", instr_ready);
            return;
        end
        instr_opc = opc; instr_rd = rd; instr_ra = ra; instr_rb = rb;
        instr_cin = cin; instr_imm = imm; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (res_valid) break;
        end
        if (!res_valid) begin
            n_checks++; n_fail++;
            $display("FAIL resp_timeout: res_valid=%0b required 1", res_valid);
            return;
        end
        data = res_data; rdo = res_rd; z = zf; n = nf;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] d, v;
        logic [1:0]  r;
        logic        z, n;
        int          lat;
        n_checks++;
        if (instr_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: ready=%0b valid=%0b required 1/0", instr_ready, res_valid);
        end
        n_checks++;
        if ({res_data, res_rd, zf, nf, alu_opc, alu_a, alu_b, alu_c} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: res_data=%h rd=%0d zf=%0b nf=%0b alu_a=%h required all 0",
                     res_data, res_rd, zf, nf, alu_a);
        end
        run_instr(3'b111, 2'd1, 2'd0, 2'd0, 1'b0, 16'h8000, d, r, z, n, lat);
        n_checks++;
        if (d !== 16'h8000 || n !== 1'b1 || z !== 1'b0) begin
            n_fail++;
            $display("FAIL load_neg: data=%h nf=%0b zf=%0b required 8000/1/0", d, n, z);
        end
        // Abort an instruction while it sits in EXEC.
        @(negedge clk);
        instr_opc = 3'b111; instr_rd = 2'd2; instr_imm = 16'h7777; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (instr_ready !== 1'b1 || res_valid !== 1'b0 || zf !== 1'b0 || nf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_exec: ready=%0b valid=%0b zf=%0b nf=%0b required 1/0/0/0",
                     instr_ready, res_valid, zf, nf);
        end
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), v);
            n_checks++;
            if (v !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_rf r%0d: got %h required 0000", i, v);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_reg(2'd2, v);
        n_checks++;
        if (v !== 16'h0000) begin
            n_fail++;
            $display("FAIL dropped_write: r2=%h required 0000", v);
        end
    endtask

    task automatic test_add;
        logic [15:0] d, v;
        logic [1:0]  r;
        logic        z, n;
        int          lat;
        run_instr(3'b111, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0005, d, r, z, n, lat);
        n_checks++;
        if (d !== 16'h0005 || r !== 2'd1 || lat != 2) begin
            n_fail++;
            $display("FAIL load_r1: data=%h rd=%0d lat=%0d required 0005/1/2", d, r, lat);
        end
        run_instr(3'b111, 2'd2, 2'd0, 2'd0, 1'b0, 16'hFFFE, d, r, z, n, lat);
        n_checks++;
        if (d !== 16'hFFFE || n !== 1'b1) begin
            n_fail++;
            $display("FAIL load_r2: data=%h nf=%0b required FFFE/1", d, n);
        end
        run_instr(3'b010, 2'd3, 2'd1, 2'd2, 1'b1, 16'h0000, d, r, z, n, lat);
        n_checks++;
        if (d !== 16'h0004 || r !== 2'd3 || z !== 1'b0 || n !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("FAIL add: data=%h rd=%0d zf=%0b nf=%0b lat=%0d required 0004/3/0/0/2",
                     d, r, z, n, lat);
        end
        read_reg(2'd3, v);
        n_checks++;
        if (v !== 16'h0004) begin
            n_fail++;
            $display("FAIL add_rf: r3=%h required 0004", v);
        end
    endtask

    task automatic test_neg_shift;
        logic [15:0] d;
        logic [1:0]  r;
        logic        z, n;
        int          lat;
        run_instr(3'b000, 2'd0, 2'd1, 2'd0, 1'b0, 16'h0000, d, r, z, n, lat);
        n_checks++;
        if (d !== 16'hFFFB || n !== 1'b1 || z !== 1'b0 || r !== 2'd0) begin
            n_fail++;
            $display("FAIL neg: data=%h nf=%0b zf=%0b rd=%0d required FFFB/1/0/0", d, n, z, r);
        end
        run_instr(3'b111, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0010, d, r, z, n, lat);
        run_instr(3'b111, 2'd2, 2'd0, 2'd0, 1'b0, 16'hFFF0, d, r, z, n, lat);
        run_instr(3'b011, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0000, d, r, z, n, lat);
        n_checks++;
        if (d !== 16'h0008 || n !== 1'b0) begin
            n_fail++;
            $display("FAIL addsh: data=%h nf=%0b required 0008/0", d, n);
        end
    endtask

    task automatic test_cat_and;
        logic [15:0] d;
        logic [1:0]  r;
        logic        z, n;
        int          lat;
        run_instr(3'b111, 2'd1, 2'd0, 2'd0, 1'b0, 16'h1234, d, r, z, n, lat);
        run_instr(3'b111, 2'd2, 2'd0, 2'd0, 1'b0, 16'hABCD, d, r, z, n, lat);
        run_instr(3'b110, 2'd0, 2'd1, 2'd2, 1'b0, 16'h0000, d, r, z, n, lat);
        n_checks++;
        if (d !== 16'h34CD || r !== 2'd0 || n !== 1'b0) begin
            n_fail++;
            $display("FAIL cat: data=%h rd=%0d nf=%0b required 34CD/0/0", d, r, n);
        end
        n_checks++;
        if (alu_opc !== 3'b110 || alu_a !== 16'h1234 || alu_b !== 16'hABCD) begin
            n_fail++;
            $display("FAIL alu_hold: opc=%b a=%h b=%h required 110/1234/ABCD", alu_opc, alu_a, alu_b);
        end
        run_instr(3'b111, 2'd1, 2'd0, 2'd0, 1'b0, 16'h00F0, d, r, z, n, lat);
        run_instr(3'b111, 2'd2, 2'd0, 2'd0, 1'b0, 16'h0F00, d, r, z, n, lat);
        run_instr(3'b100, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0000, d, r, z, n, lat);
        n_checks++;
        if (d !== 16'h0000 || z !== 1'b1) begin
            n_fail++;
            $display("FAIL and: data=%h zf=%0b required 0000/1", d, z);
        end
        run_instr(3'b101, 2'd0, 2'd1, 2'd2, 1'b0, 16'h0000, d, r, z, n, lat);
        n_checks++;
        if (d !== 16'h0FF0 || z !== 1'b0) begin
            n_fail++;
            $display("FAIL or: data=%h zf=%0b required 0FF0/0", d, z);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] v;
        int          waits;
        // r1 = 00F0, r3 = 0000 from the previous scenario.
        @(negedge clk);
        instr_opc = 3'b001; instr_rd = 2'd2; instr_ra = 2'd1; instr_rb = 2'd1;
        instr_cin = 1'b0; instr_imm = 16'h0000; instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_opc = 3'b111; instr_rd = 2'd3; instr_imm = 16'h5555;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            read_reg(2'd3, v);
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 16'h00F1 || res_rd !== 2'd2 ||
                instr_ready !== 1'b0 || v !== 16'h0000) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: valid=%0b data=%h rd=%0d ready=%0b r3=%h required 1/00F1/2/0/0000",
                         i, res_valid, res_data, res_rd, instr_ready, v);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        n_checks++;
        if (instr_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release: ready=%0b valid=%0b required 1/0", instr_ready, res_valid);
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        waits = 0;
        while (waits < 20) begin
            @(negedge clk);
            waits++;
            if (res_valid) break;
        end
        read_reg(2'd3, v);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h5555 || res_rd !== 2'd3 || v !== 16'h5555 || waits != 2) begin
            n_fail++;
            $display("FAIL pending_instr: valid=%0b data=%h rd=%0d r3=%h lat=%0d required 1/5555/3/5555/2",
                     res_valid, res_data, res_rd, v, waits);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic test_self_overwrite;
        logic [15:0] d, v;
        logic [1:0]  r;
        logic        z, n;
        int          lat;
        run_instr(3'b111, 2'd0, 2'd0, 2'd0, 1'b0, 16'hFFFF, d, r, z, n, lat);
        run_instr(3'b001, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0000, d, r, z, n, lat);
        read_reg(2'd0, v);
        n_checks++;
        if (d !== 16'h0000 || z !== 1'b1 || n !== 1'b0 || v !== 16'h0000) begin
            n_fail++;
            $display("FAIL self_overwrite: data=%h zf=%0b nf=%0b r0=%h required 0000/1/0/0000",
                     d, z, n, v);
        end
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr_opc = 3'b000; instr_rd = 2'd0;
        instr_ra = 2'd0; instr_rb = 2'd0; instr_cin = 1'b0; instr_imm = 16'h0000;
        res_ready = 1'b0; dbg_sel = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_add();
        test_neg_shift();
        test_cat_and();
        test_back_to_back();
        test_self_overwrite();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
